// File: rtl/dyser_send_queue.sv
// Per-port input queue bank between the core's dual-lane send interface and the
// DySER fabric input ports: NUM_PORTS independent FIFOs with all-or-nothing accept.
module dyser_send_queue #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_PORTS  = 8,
  parameter int unsigned PORT_BITS  = 3,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_BITS   = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           send_data_r0,
  input  logic [PORT_BITS-1:0]            send_port_r0,
  input  logic                            send_en0,
  input  logic [DATA_WIDTH-1:0]           send_data_r1,
  input  logic [PORT_BITS-1:0]            send_port_r1,
  input  logic                            send_en1,
  output logic                            send_stall,
  input  logic                            flush,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_PORTS-1:0]            out_valid,
  input  logic [NUM_PORTS-1:0]            out_ready,
  output logic                            bad_port
);

  localparam int unsigned PTR_BITS = CNT_BITS - 1;
  localparam logic [CNT_BITS-1:0]  DEPTH_C     = CNT_BITS'(DEPTH);
  localparam logic [PORT_BITS:0]   NUM_PORTS_C = (PORT_BITS+1)'(NUM_PORTS);

  logic                 lane0_bad;
  logic                 lane1_bad;
  logic                 accept;
  logic [NUM_PORTS-1:0] over;

  assign lane0_bad  = send_en0 && ({1'b0, send_port_r0} >= NUM_PORTS_C);
  assign lane1_bad  = send_en1 && ({1'b0, send_port_r1} >= NUM_PORTS_C);

  // Space is judged from registered counts only; any overcommitted port stalls both lanes.
  assign send_stall = flush | (|over);
  assign accept     = ~send_stall;

  // Sticky out-of-range indication; flush discards the cycle's activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_port <= 1'b0;
    end else if (!flush && (lane0_bad || lane1_bad)) begin
      bad_port <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CNT_BITS-1:0]   count_q;
    logic [PTR_BITS-1:0]   wr_ptr_q;
    logic [PTR_BITS-1:0]   rd_ptr_q;
    logic [PTR_BITS-1:0]   wr1_ptr;
    logic [CNT_BITS-1:0]   need;
    logic                  hit0;
    logic                  hit1;
    logic                  push0;
    logic                  push1;
    logic                  pop;

    assign hit0    = send_en0 && (send_port_r0 == PORT_BITS'(p));
    assign hit1    = send_en1 && (send_port_r1 == PORT_BITS'(p));
    assign need    = CNT_BITS'(hit0) + CNT_BITS'(hit1);
    assign over[p] = need > (DEPTH_C - count_q);
    assign push0   = accept && hit0;
    assign push1   = accept && hit1;
    assign pop     = (count_q != '0) && out_ready[p];

    // Lane 1 lands behind lane 0 when both target this port.
    assign wr1_ptr = push0 ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;

    assign out_valid[p]                           = (count_q != '0);
    assign out_data[p*DATA_WIDTH +: DATA_WIDTH]   = mem[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else if (flush) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        count_q  <= count_q + CNT_BITS'(push0) + CNT_BITS'(push1) - CNT_BITS'(pop);
        wr_ptr_q <= wr_ptr_q + PTR_BITS'(push0) + PTR_BITS'(push1);
        rd_ptr_q <= rd_ptr_q + PTR_BITS'(pop);
      end
    end

    // Storage is not reset; contents are meaningless while the FIFO is empty.
    always_ff @(posedge clk) begin
      if (push0) mem[wr_ptr_q] <= send_data_r0;
      if (push1) mem[wr1_ptr]  <= send_data_r1;
    end
  end

endmodule

// File: tb/tb_dyser_send_queue.sv
// Scoreboard bench for dyser_send_queue: per-port expected queues filled on accepted
// sends, compared against FIFO heads and drained on pops.
module tb_dyser_send_queue;

  localparam int unsigned DW = 64;
  localparam int unsigned NP = 8;
  localparam int unsigned PB = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DW-1:0]    send_data_r0 = '0;
  logic [PB-1:0]    send_port_r0 = '0;
  logic             send_en0 = 1'b0;
  logic [DW-1:0]    send_data_r1 = '0;
  logic [PB-1:0]    send_port_r1 = '0;
  logic             send_en1 = 1'b0;
  logic             flush = 1'b0;
  logic [NP-1:0]    out_ready = '0;
  logic             send_stall;
  logic [NP*DW-1:0] out_data;
  logic [NP-1:0]    out_valid;
  logic             bad_port;

  // Narrow instance (6 ports) shares the inputs so ports 6/7 are out of range there.
  logic             send_stall6;
  logic [6*DW-1:0]  out_data6;
  logic [5:0]       out_valid6;
  logic             bad_port6;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q [NP][$];
  logic          exp_bad6 = 1'b0;

  dyser_send_queue u_dut (
    .clk(clk), .rst(rst),
    .send_data_r0(send_data_r0), .send_port_r0(send_port_r0), .send_en0(send_en0),
    .send_data_r1(send_data_r1), .send_port_r1(send_port_r1), .send_en1(send_en1),
    .send_stall(send_stall), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .bad_port(bad_port)
  );

  dyser_send_queue #(.NUM_PORTS(6)) u_dut6 (
    .clk(clk), .rst(rst),
    .send_data_r0(send_data_r0), .send_port_r0(send_port_r0), .send_en0(send_en0),
    .send_data_r1(send_data_r1), .send_port_r1(send_port_r1), .send_en1(send_en1),
    .send_stall(send_stall6), .flush(flush),
    .out_data(out_data6), .out_valid(out_valid6), .out_ready(out_ready[5:0]),
    .bad_port(bad_port6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++) exp_q[p].delete();
  endtask

  // One clock: drive at negedge, check state/stall, update the model for the next edge.
  task automatic cycle(input bit e0, input int p0, input logic [DW-1:0] d0,
                       input bit e1, input int p1, input logic [DW-1:0] d1,
                       input logic [NP-1:0] rdy, input bit fl);
    logic          exp_stall;
    logic [NP-1:0] exp_valid;
    int            need;
    @(negedge clk);
    send_en0 = e0; send_port_r0 = PB'(p0); send_data_r0 = d0;
    send_en1 = e1; send_port_r1 = PB'(p1); send_data_r1 = d1;
    out_ready = rdy; flush = fl;
    #1;
    exp_stall = fl;
    for (int p = 0; p < NP; p++) begin
      need = ((e0 && p0 == p) ? 1 : 0) + ((e1 && p1 == p) ? 1 : 0);
      if (need > 4 - exp_q[p].size()) exp_stall = 1'b1;
      exp_valid[p] = (exp_q[p].size() != 0);
      if (exp_q[p].size() != 0)
        check($sformatf("head%0d", p), out_data[p*DW +: DW], exp_q[p][0]);
    end
    check("stall", DW'(send_stall), DW'(exp_stall));
    check("valid", DW'(out_valid), DW'(exp_valid));
    check("bad_port", DW'(bad_port), '0);
    check("bad_port6", DW'(bad_port6), DW'(exp_bad6));
    for (int p = 0; p < NP; p++)
      if (rdy[p] && exp_q[p].size() != 0) void'(exp_q[p].pop_front());
    if (fl) begin
      clear_model();
    end else if (!exp_stall) begin
      if (e0 && p0 < NP) exp_q[p0].push_back(d0);
      if (e1 && p1 < NP) exp_q[p1].push_back(d1);
    end
    if (!fl && ((e0 && p0 >= 6) || (e1 && p1 >= 6))) exp_bad6 = 1'b1;
  endtask

  task automatic idle(input logic [NP-1:0] rdy);
    cycle(0, 0, '0, 0, 0, '0, rdy, 0);
  endtask

  initial begin
    @(negedge clk); #1;
    check("rst_valid", DW'(out_valid), '0);
    check("rst_bad", DW'(bad_port), '0);
    check("rst_stall", DW'(send_stall), '0);
    rst = 1'b0;

    // 1: two lanes to different ports
    cycle(1, 4, 64'h0, 1, 3, 64'h1, '0, 0);
    idle('0);
    check("t1_valid", DW'(out_valid), 64'h18);
    idle(8'h18);

    // 2: both lanes to one port, drained in order
    cycle(1, 2, 64'hA, 1, 2, 64'hB, '0, 0);
    idle(8'h04);
    idle(8'h04);
    idle('0);

    // 3: full port stalls both lanes; pop frees space only on the following cycle
    for (int i = 0; i < 4; i++) cycle(1, 5, 64'h100 + DW'(i), 0, 0, '0, '0, 0);
    cycle(1, 5, 64'h55, 1, 6, 64'h66, '0, 0);
    check("t3_port6_empty", DW'(out_valid[6]), '0);
    cycle(1, 5, 64'h55, 1, 6, 64'h66, 8'h20, 0);
    cycle(1, 5, 64'h55, 1, 6, 64'h66, '0, 0);
    for (int i = 0; i < 5; i++) idle(8'h60);

    // 4: three entries leave room for one lane but not two
    for (int i = 0; i < 3; i++) cycle(1, 1, 64'h200 + DW'(i), 0, 0, '0, '0, 0);
    cycle(1, 1, 64'h210, 1, 1, 64'h211, '0, 0);
    cycle(0, 0, '0, 1, 1, 64'h211, '0, 0);
    for (int i = 0; i < 4; i++) idle(8'h02);

    // 5: flush with a concurrent send
    cycle(1, 0, 64'h300, 1, 3, 64'h303, '0, 0);
    cycle(1, 7, 64'h307, 0, 0, '0, '0, 0);
    cycle(1, 2, 64'h302, 0, 0, '0, 8'h01, 1);
    cycle(1, 2, 64'h312, 0, 0, '0, '0, 0);
    idle(8'h04);

    // 6: streaming through port 0 wraps the pointers
    cycle(1, 0, 64'd1, 0, 0, '0, '0, 0);
    for (int k = 2; k <= 10; k++) cycle(1, 0, DW'(k), 0, 0, '0, 8'h01, 0);
    idle(8'h01);
    idle('0);

    // Asynchronous reset mid-operation
    cycle(1, 0, 64'h400, 1, 2, 64'h402, '0, 0);
    cycle(1, 0, 64'h401, 0, 0, '0, '0, 0);
    idle('0);
    @(negedge clk);
    send_en0 = 1'b0; send_en1 = 1'b0; out_ready = '0;
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_valid", DW'(out_valid), '0);
    check("rst_async_bad6", DW'(bad_port6), '0);
    clear_model();
    exp_bad6 = 1'b0;
    #1;
    rst = 1'b0;
    cycle(1, 3, 64'h500, 0, 0, '0, '0, 0);
    idle(8'h08);
    idle('0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
